sram_1rw_wmask_ctrl: RTL and testbench
======================================

# sram_1rw_wmask_ctrl

Parametrised single-port (1RW) synchronous SRAM macro model with per-byte write masks, a configurable read pipeline and registered read-valid strobe. It is the next-generation drop-in for the fixed 8-bit OpenRAM-style memories behind the AHB SRAM slave. It generalises width and depth, adds byte-lane writes and write-through mode, and optionally clears the array after reset. The model is synthesizable and carries no `#` delays.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 13, address bits; RAM_DEPTH = 1 << ADDR_WIDTH.
- NUM_WMASKS, DATA_WIDTH/8, byte lanes (derived; do not override).
- READ_LATENCY, 1, cycles from acceptance edge to data; legal 1..3.
- WRITE_THROUGH, 0, 1 = an accepted write also returns the merged word on dout0.

Ports:
- clk0  in  1  clock; all state on rising edge.
- rst0  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- csb0  in  1  active-low chip select.
- web0  in  1  active-low write enable.
- wmask0  in  NUM_WMASKS  byte-lane write enable; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  word address.
- din0  in  DATA_WIDTH  write data.
- dout0  out  DATA_WIDTH  read data; holds its last value when dvalid0 = 0.
- dvalid0  out  1  one-cycle strobe marking new data on dout0.
- rdy0  out  1  array accepts requests.

## Operation
- Reset values:
  - rdy0 = 0, dvalid0 = 0, dout0 = 0.
  - Read pipeline flushed.
  - State = INIT if SRAM_INIT_CLEAR_EN is defined, else READY.
- States:
  - INIT: init counter walks 0..RAM_DEPTH-1, writing all-zero words; rdy0 = 0. After the write to RAM_DEPTH-1, go to READY.
  - READY: rdy0 = 1; stays here until rst0.
- Acceptance: a request is accepted on a rising edge with rdy0 = 1 and csb0 = 0. csb0 = 0 while rdy0 = 0 is ignored: no write, no response.
- Write (web0 = 0):
  - Lanes with wmask0[i] = 1 are updated at the acceptance edge; other lanes are unchanged.
  - wmask0 = 0 is a legal no-op write.
- Read (web0 = 1):
  - Array is sampled at the acceptance edge.
  - A read that follows a write to the same address in the next cycle returns the new data.
- Write-through (WRITE_THROUGH = 1): an accepted write produces a response like a read, carrying the post-merge word.
- Pipeline:
  - One request per cycle, fully pipelined; responses come back in order.
  - No backpressure: the consumer must take dvalid0 when it fires.
- Reset mid-operation: in-flight responses are discarded and dvalid0 is 0 from the reset edge. Array contents are kept unless INIT clears them.

## Timing
- Request accepted at edge T → dout0/dvalid0 updated at edge T+READ_LATENCY. dvalid0 is high for exactly one cycle per response.
- Back-to-back reads at T, T+1 → dvalid0 high at T+L and T+L+1 (L = READ_LATENCY) with no gap.
- INIT takes RAM_DEPTH cycles. rdy0 rises at edge RAM_DEPTH+1 after the first edge with rst0 = 0.
- Without INIT, rdy0 rises at the first edge with rst0 = 0.
- rst0 asserted during INIT restarts the init counter at 0.

## Configuration
- SRAM_INIT_CLEAR_EN defined:
  - INIT state and address counter are compiled in.
  - Every reset zero-fills the whole array before rdy0 = 1.
- Not defined:
  - No INIT state; rdy0 = 1 the cycle after reset releases.
  - Array content is preserved across reset (X after power-up in simulation).

## Test plan
- Init clear: SRAM_INIT_CLEAR_EN on, ADDR_WIDTH = 4, release rst0 → rdy0 = 0 for 16 cycles, then 1. Reads of addresses 0..15 return 0x00000000.
- Byte-masked write: write 0xAABBCCDD to addr 5 with wmask0 = 4'b1111, then 0x11223344 with wmask0 = 4'b0101 → read addr 5 returns 0xAA22CC44.
- Pipelined reads: READ_LATENCY = 3, reads to addrs 1, 2, 3 on consecutive cycles → dvalid0 high for 3 consecutive cycles starting 3 edges after the first acceptance, data in order.
- Write-through: WRITE_THROUGH = 1, write 0xDEADBEEF with wmask0 = 4'b0011 over 0x01020304 → response 0x0102BEEF after READ_LATENCY; with WRITE_THROUGH = 0, no dvalid0 for that write.
- Ignored request: csb0 = 0 with rdy0 = 0 during INIT writing 0xFF to addr 2 → addr 2 reads 0 after init, no dvalid0.
- Reset mid-read: assert rst0 one cycle after a read accept with READ_LATENCY = 2 → dvalid0 never fires for it. Data written before reset is still readable (macro off).

Source files
------------

// File: rtl/sram_1rw_wmask_ctrl.sv
// sram_1rw_wmask_ctrl
// Single-port (1RW) synchronous SRAM model with per-byte write masks,
// a 1..3 stage read pipeline and a registered read-valid strobe.
//
// Optional build macro: SRAM_INIT_CLEAR_EN
//   defined   -> after every reset the array is zero-filled (INIT state)
//                before rdy0 rises.
//   undefined -> no INIT state; rdy0 rises on the first clock after reset
//                releases and array contents survive reset.
//
// Ports:
//   clk0     clock, all state on rising edge
//   rst0     synchronous active-high reset
//   csb0     active-low chip select
//   web0     active-low write enable
//   wmask0   byte-lane write enables (bit i covers din0[8i+7:8i])
//   addr0    word address
//   din0     write data
//   dout0    read data, holds last value while dvalid0 = 0
//   dvalid0  one-cycle strobe marking new data on dout0
//   rdy0     array accepts requests
module sram_1rw_wmask_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 13,
  parameter int unsigned NUM_WMASKS    = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_THROUGH = 0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  output logic                  rdy0
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_READY = 1'b1;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [0:0] state;
  logic       rdy_q;
  logic       accept;
  logic       wr_en;

  // Requests are only taken while rdy0 is already high at the edge; a
  // reset edge never accepts.
  assign accept = rdy_q && !csb0 && !rst0;
  assign wr_en  = accept && !web0;
  assign rdy0   = rdy_q;

`ifdef SRAM_INIT_CLEAR_EN
  localparam logic [0:0] ST_INIT = 1'b0;

  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_we;

  assign init_we = (state == ST_INIT) && !rst0;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == '1) begin
        state <= ST_READY;
      end
    end
  end
`else
  assign state = ST_READY;
`endif

  // rdy0 is registered from the state, so it trails the INIT->READY
  // transition by one clock; this also keeps the init writes and request
  // writes mutually exclusive in the array block below.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= (state == ST_READY);
    end
  end

  // Array: no reset, contents persist unless the INIT walk clears them.
  always_ff @(posedge clk0) begin
`ifdef SRAM_INIT_CLEAR_EN
    if (init_we) begin
      mem[init_cnt] <= '0;
    end
`endif
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][8*i +: 8] <= din0[8*i +: 8];
        end
      end
    end
  end

  // Stage 0: captured at the acceptance edge. The old word is sampled at
  // the same edge as the write, and the merge happens afterwards, so a
  // write-through response carries the post-merge word.
  logic                  s0_v;
  logic                  s0_wr;
  logic [NUM_WMASKS-1:0] s0_mask;
  logic [DATA_WIDTH-1:0] s0_din;
  logic [DATA_WIDTH-1:0] s0_old;
  logic [DATA_WIDTH-1:0] s0_word;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      s0_v    <= 1'b0;
      s0_wr   <= 1'b0;
      s0_mask <= '0;
      s0_din  <= '0;
      s0_old  <= '0;
    end else begin
      s0_v <= accept && (web0 || (WRITE_THROUGH != 0));
      if (accept) begin
        s0_wr   <= !web0;
        s0_mask <= wmask0;
        s0_din  <= din0;
        s0_old  <= mem[addr0];
      end
    end
  end

  always_comb begin
    s0_word = s0_old;
    if (s0_wr) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (s0_mask[i]) begin
          s0_word[8*i +: 8] = s0_din[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline: stage k is loaded at acceptance edge + k. Data only
  // moves with a valid token so the last stage (dout0) holds between
  // responses.
  logic                  stage_v [1:READ_LATENCY];
  logic [DATA_WIDTH-1:0] stage_d [1:READ_LATENCY];

  always_ff @(posedge clk0) begin
    if (rst0) begin
      for (int unsigned k = 1; k <= READ_LATENCY; k++) begin
        stage_v[k] <= 1'b0;
        stage_d[k] <= '0;
      end
    end else begin
      stage_v[1] <= s0_v;
      if (s0_v) begin
        stage_d[1] <= s0_word;
      end
      for (int unsigned k = 2; k <= READ_LATENCY; k++) begin
        stage_v[k] <= stage_v[k-1];
        if (stage_v[k-1]) begin
          stage_d[k] <= stage_d[k-1];
        end
      end
    end
  end

  assign dout0   = stage_d[READ_LATENCY];
  assign dvalid0 = stage_v[READ_LATENCY];

endmodule

// File: tb/tb_sram_1rw_wmask_ctrl.sv
// tb_sram_1rw_wmask_ctrl
// Directed bench for sram_1rw_wmask_ctrl. Three instances share all inputs:
//   u_a: ADDR_WIDTH 4, READ_LATENCY 1, WRITE_THROUGH 0
//   u_b: ADDR_WIDTH 4, READ_LATENCY 3, WRITE_THROUGH 1
//   u_c: ADDR_WIDTH 4, READ_LATENCY 2, WRITE_THROUGH 0
// Works with or without SRAM_INIT_CLEAR_EN defined.
module tb_sram_1rw_wmask_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb;
  logic        web;
  logic [3:0]  wmask;
  logic [3:0]  addr;
  logic [31:0] din;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        dvalid_a, dvalid_b, dvalid_c;
  logic        rdy_a, rdy_b, rdy_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_1rw_wmask_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_THROUGH(0)) u_a (
    .clk0(clk), .rst0(rst), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr),
    .din0(din), .dout0(dout_a), .dvalid0(dvalid_a), .rdy0(rdy_a));

  sram_1rw_wmask_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(3), .WRITE_THROUGH(1)) u_b (
    .clk0(clk), .rst0(rst), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr),
    .din0(din), .dout0(dout_b), .dvalid0(dvalid_b), .rdy0(rdy_b));

  sram_1rw_wmask_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_THROUGH(0)) u_c (
    .clk0(clk), .rst0(rst), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr),
    .din0(din), .dout0(dout_c), .dvalid0(dvalid_c), .rdy0(rdy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    csb = 1'b1; web = 1'b1; wmask = '0; addr = '0; din = '0;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb = 1'b0; web = 1'b0; addr = a; din = d; wmask = m;
  endtask

  task automatic drive_read(input logic [3:0] a);
    csb = 1'b0; web = 1'b1; addr = a; wmask = '0; din = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    drive_write(a, d, m);
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", rdy_a); end
    n_checks++; if (dvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_a: got %b expected 0", dvalid_a); end
    n_checks++; if (dout_a !== 32'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h expected 00000000", dout_a); end
    n_checks++; if (dvalid_b !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_b: got %b expected 0", dvalid_b); end
    n_checks++; if (dout_b !== 32'h0) begin n_fail++; $display("FAIL reset_dout_b: got %h expected 00000000", dout_b); end
    rst = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
    // Edges 1..16 after release walk the array; rdy0 rises at edge 17.
    // A write to addr 2 is attempted while rdy0 = 0 and must be ignored.
    for (int k = 1; k <= 17; k++) begin
      if (k >= 3 && k <= 5) drive_write(4'd2, 32'h000000FF, 4'b1111);
      else drive_idle();
      tick();
      n_checks++; if (rdy_a !== (k == 17)) begin n_fail++; $display("FAIL init_rdy edge %0d: got %b expected %b", k, rdy_a, (k == 17)); end
      n_checks++; if (dvalid_b !== 1'b0) begin n_fail++; $display("FAIL init_dvalid_b edge %0d: got %b expected 0", k, dvalid_b); end
    end
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) drive_read(4'(c));
      else drive_idle();
      tick();
      if (c >= 1) begin
        n_checks++; if (dvalid_a !== 1'b1 || dout_a !== 32'h0) begin n_fail++; $display("FAIL init_clear addr %0d: got v=%b d=%h expected v=1 d=00000000", c - 1, dvalid_a, dout_a); end
      end
    end
`else
    tick();
    n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL release_rdy_a: got %b expected 1", rdy_a); end
    n_checks++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL release_rdy_b: got %b expected 1", rdy_b); end
    n_checks++; if (rdy_c !== 1'b1) begin n_fail++; $display("FAIL release_rdy_c: got %b expected 1", rdy_c); end
`endif
  endtask

  task automatic test_byte_mask();
    do_write(4'd5, 32'hAABBCCDD, 4'b1111);
    do_write(4'd5, 32'h11223344, 4'b0101);
    drive_read(4'd5);
    tick();
    drive_idle();
    n_checks++; if (dvalid_a !== 1'b0) begin n_fail++; $display("FAIL mask_early: got %b expected 0", dvalid_a); end
    tick();
    n_checks++; if (dvalid_a !== 1'b1) begin n_fail++; $display("FAIL mask_dvalid: got %b expected 1", dvalid_a); end
    n_checks++; if (dout_a !== 32'hAA22CC44) begin n_fail++; $display("FAIL mask_data: got %h expected aa22cc44", dout_a); end
    tick();
    n_checks++; if (dvalid_a !== 1'b0) begin n_fail++; $display("FAIL mask_strobe_len: got %b expected 0", dvalid_a); end
    n_checks++; if (dout_a !== 32'hAA22CC44) begin n_fail++; $display("FAIL mask_hold: got %h expected aa22cc44", dout_a); end
    // An all-zero mask is a legal no-op write.
    do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
    drive_read(4'd5);
    tick();
    drive_idle();
    tick();
    n_checks++; if (dvalid_a !== 1'b1 || dout_a !== 32'hAA22CC44) begin n_fail++; $display("FAIL mask_zero: got v=%b d=%h expected v=1 d=aa22cc44", dvalid_a, dout_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [3];
    v[0] = 32'h0000A001; v[1] = 32'h0000B002; v[2] = 32'h0000C003;
    do_write(4'd1, v[0], 4'b1111);
    do_write(4'd2, v[1], 4'b1111);
    do_write(4'd3, v[2], 4'b1111);
    repeat (4) tick();
    for (int c = 0; c <= 6; c++) begin
      if (c < 3) drive_read(4'(c + 1));
      else drive_idle();
      tick();
      n_checks++; if (dvalid_a !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL b2b_dvalid_a c%0d: got %b expected %b", c, dvalid_a, (c >= 1 && c <= 3)); end
      if (c >= 1 && c <= 3) begin
        n_checks++; if (dout_a !== v[c-1]) begin n_fail++; $display("FAIL b2b_data_a c%0d: got %h expected %h", c, dout_a, v[c-1]); end
      end
      n_checks++; if (dvalid_c !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL b2b_dvalid_c c%0d: got %b expected %b", c, dvalid_c, (c >= 2 && c <= 4)); end
      if (c >= 2 && c <= 4) begin
        n_checks++; if (dout_c !== v[c-2]) begin n_fail++; $display("FAIL b2b_data_c c%0d: got %h expected %h", c, dout_c, v[c-2]); end
      end
      n_checks++; if (dvalid_b !== (c >= 3 && c <= 5)) begin n_fail++; $display("FAIL pipe3_dvalid_b c%0d: got %b expected %b", c, dvalid_b, (c >= 3 && c <= 5)); end
      if (c >= 3 && c <= 5) begin
        n_checks++; if (dout_b !== v[c-3]) begin n_fail++; $display("FAIL pipe3_data_b c%0d: got %h expected %h", c, dout_b, v[c-3]); end
      end
      if (c == 6) begin
        n_checks++; if (dout_b !== v[2]) begin n_fail++; $display("FAIL pipe3_hold_b: got %h expected %h", dout_b, v[2]); end
      end
    end
  endtask

  task automatic test_write_through();
    do_write(4'd7, 32'h01020304, 4'b1111);
    repeat (4) tick();
    do_write(4'd7, 32'hDEADBEEF, 4'b0011);
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++; if (dvalid_b !== (c == 3)) begin n_fail++; $display("FAIL wt_dvalid_b c%0d: got %b expected %b", c, dvalid_b, (c == 3)); end
      if (c == 3) begin
        n_checks++; if (dout_b !== 32'h0102BEEF) begin n_fail++; $display("FAIL wt_data_b: got %h expected 0102beef", dout_b); end
      end
      n_checks++; if (dvalid_a !== 1'b0) begin n_fail++; $display("FAIL wt_off_dvalid_a c%0d: got %b expected 0", c, dvalid_a); end
      n_checks++; if (dvalid_c !== 1'b0) begin n_fail++; $display("FAIL wt_off_dvalid_c c%0d: got %b expected 0", c, dvalid_c); end
    end
    drive_read(4'd7);
    tick();
    drive_idle();
    tick();
    n_checks++; if (dvalid_a !== 1'b1 || dout_a !== 32'h0102BEEF) begin n_fail++; $display("FAIL wt_readback_a: got v=%b d=%h expected v=1 d=0102beef", dvalid_a, dout_a); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] exp9;
    do_write(4'd9, 32'h5A5AA5A5, 4'b1111);
    do_write(4'd2, 32'h00000000, 4'b1111);
    repeat (4) tick();
    drive_read(4'd9);
    tick();
    // Reset one cycle after the accept; a write to addr 2 is held through
    // the reset edge and the first edge after release (rdy0 still 0).
    rst = 1'b1;
    drive_write(4'd2, 32'h000000FF, 4'b1111);
    tick();
    n_checks++; if (dvalid_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dvalid_a: got %b expected 0", dvalid_a); end
    n_checks++; if (dvalid_c !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dvalid_c: got %b expected 0", dvalid_c); end
    n_checks++; if (dout_c !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dout_c: got %h expected 00000000", dout_c); end
    n_checks++; if (rdy_c !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdy_c: got %b expected 0", rdy_c); end
    rst = 1'b0;
    tick();
    drive_idle();
    n_checks++; if (dvalid_c !== 1'b0) begin n_fail++; $display("FAIL rst_mid_late_c: got %b expected 0", dvalid_c); end
`ifdef SRAM_INIT_CLEAR_EN
    exp9 = 32'h0;
    repeat (16) tick();
`else
    exp9 = 32'h5A5AA5A5;
`endif
    n_checks++; if (rdy_c !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rdy_back: got %b expected 1", rdy_c); end
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) drive_read(4'd9);
      else if (c == 1) drive_read(4'd2);
      else drive_idle();
      tick();
      if (c <= 2) begin
        n_checks++; if (dvalid_b !== 1'b0) begin n_fail++; $display("FAIL ignored_wr_dvalid_b c%0d: got %b expected 0", c, dvalid_b); end
      end
      if (c == 2) begin
        n_checks++; if (dvalid_c !== 1'b1 || dout_c !== exp9) begin n_fail++; $display("FAIL rst_keep_addr9: got v=%b d=%h expected v=1 d=%h", dvalid_c, dout_c, exp9); end
      end
      if (c == 3) begin
        n_checks++; if (dvalid_c !== 1'b1 || dout_c !== 32'h0) begin n_fail++; $display("FAIL ignored_wr_addr2: got v=%b d=%h expected v=1 d=00000000", dvalid_c, dout_c); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_byte_mask();
    test_back_to_back();
    test_write_through();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
